shift_issue_queue: RTL and testbench
====================================

// Module: shift_issue_queue
// PURPOSE
//  Request queue and result register wrapped around the combinational shifter.
//  Buffers shift ops {control, shamt, data} from the producer (valid/ready) in a FIFO.
//  Presents the head entry to the shifter and registers the shifter's result toward the consumer (valid/ready).
//  Decouples producer stalls from consumer stalls; ops complete in order.
// PARAMETERS
//  WIDTH  8  data width; must match the shifter's WIDTH
//  DEPTH  4  FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                  single clock, rising edge
//  rst_n       in   1                  asynchronous, active-low reset
//  flush       in   1                  sync clear of FIFO and result register
//  in_valid    in   1                  producer op valid
//  in_ready    out  1                  queue can accept (= !full)
//  in_control  in   2                  00 LSL, 01 LSR, 10 ASR, 11 RR
//  in_shamt    in   5                  shift amount
//  in_data     in   WIDTH              operand
//  sh_control  out  2                  head control to shifter
//  sh_shamt    out  5                  head shamt to shifter
//  sh_data     out  WIDTH              head data to shifter
//  sh_result   in   WIDTH              shifter OUT (combinational, same cycle)
//  res_valid   out  1                  result register holds an unconsumed result
//  res_ready   in   1                  consumer accepts result
//  res_data    out  WIDTH              registered shift result
//  res_control out  2                  control tag of res_data
//  level       out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH (excludes result reg)
// BEHAVIOUR
//  Reset (rst_n=0, async): rd/wr ptrs=0, level=0, res_valid=0, res_data=0, res_control=0; in_ready=1.
//  push = in_valid & in_ready; in_ready = (level!=DEPTH). No pass-through when full: a same-cycle pop does not free a slot for that cycle's push.
//  sh_* = head entry fields when level>0; all zero when empty.
//  pop = (level>0) & (!res_valid | res_ready).
//  On pop: res_data<=sh_result, res_control<=head control, res_valid<=1.
//  Else if res_valid & res_ready: res_valid<=0, res_data held.
//  Simultaneous push & pop: level unchanged, both pointers advance.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  Full/empty is decided by level, not by pointer compare.
//  Latency: op accepted at edge N -> res_valid=1 after edge N+1, min 2 cycles.
//  Throughput 1 op/cycle sustained when res_ready=1.
//  Backpressure: while res_valid & !res_ready, res_data/res_control stay stable; FIFO keeps filling.
//  Capacity: DEPTH+1 ops in flight (DEPTH in FIFO + 1 in result reg).
//  flush=1 at an edge: ptrs=0, level=0, res_valid=0; that cycle's push and pop are discarded.
//  flush has priority over push/pop; res_data is not cleared by flush.
//  No width checks on shamt; it is passed unchanged (shamt>=WIDTH is handled by the shifter).
//  Reset asserted mid-stream discards all queued ops immediately, without waiting for an edge.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with level=3 -> immediately level=0, res_valid=0, in_ready=1.
//  2 Single ops, WIDTH=8, bench shifter model:
//      LSL 8'h81 sh1 -> res_data 8'h02
//      ASR 8'h80 sh3 -> 8'hF0
//      RR  8'h81 sh1 -> 8'hC0
//    Each appears 2 edges after acceptance, with res_control matching.
//  3 Fill: res_ready=0, push continuously -> exactly 5 ops accepted (DEPTH+1).
//    Then in_ready=0, level=4, res_data=first op's result, stable.
//  4 Drain/order: from state 3, res_ready=1 -> 5 results in push order on consecutive cycles.
//    Then res_valid=0, level=0.
//  5 Wrap/throughput: 10 back-to-back LSL ops data=i sh=1, res_ready=1.
//    -> results 2*i in order, one per cycle after the 2-cycle fill; no bubbles across pointer wrap.
//  6 Flush: 3 queued plus a push in the same cycle as flush=1 -> next cycle level=0, res_valid=0, in_ready=1.
//    The pushed op never emerges.

Source files
------------

// File: rtl/shift_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_issue_queue                                                |
// | Brief   : op FIFO in front of a combinational shifter, result reg behind.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_issue_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_control,
  input  logic [4:0]               in_shamt,
  input  logic [WIDTH-1:0]         in_data,
  output logic [1:0]               sh_control,
  output logic [4:0]               sh_shamt,
  output logic [WIDTH-1:0]         sh_data,
  input  logic [WIDTH-1:0]         sh_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [1:0]               res_control,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

  logic [1:0]         r_ctl_mem [DEPTH];
  logic [4:0]         r_sha_mem [DEPTH];
  logic [WIDTH-1:0]   r_dat_mem [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               r_res_valid;
  logic [WIDTH-1:0]   r_res_data;
  logic [1:0]         r_res_control;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == c_FULL_LVL);
  assign w_push   = in_valid & ~w_full;
  assign w_pop    = ~w_empty & (~r_res_valid | res_ready);

  assign in_ready = ~w_full;
  assign level    = r_level;

  assign sh_control = w_empty ? 2'b00      : r_ctl_mem[r_rd_ptr];
  assign sh_shamt   = w_empty ? 5'b00000   : r_sha_mem[r_rd_ptr];
  assign sh_data    = w_empty ? '0         : r_dat_mem[r_rd_ptr];

  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_control = r_res_control;

  // Payload storage needs no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_ctl_mem[r_wr_ptr] <= in_control;
      r_sha_mem[r_wr_ptr] <= in_shamt;
      r_dat_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_control <= 2'b00;
    end else if (flush) begin
      // res_data is deliberately left holding its last value.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_res_data    <= sh_result;
        r_res_control <= sh_control;
        r_res_valid   <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_queue.sv
`default_nettype none
// Bench for shift_issue_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_shift_issue_queue;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [1:0]   in_control = 2'b00;
  logic [4:0]   in_shamt = 5'd0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         res_valid;
  logic [1:0]   sh_control;
  logic [1:0]   res_control;
  logic [4:0]   sh_shamt;
  logic [W-1:0] sh_data;
  logic [W-1:0] sh_result;
  logic [W-1:0] res_data;
  logic [2:0]   level;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_shamt(in_shamt), .in_data(in_data),
    .sh_control(sh_control), .sh_shamt(sh_shamt), .sh_data(sh_data),
    .sh_result(sh_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_control(res_control),
    .level(level)
  );

  // Shifter: 00 LSL, 01 LSR, 10 ASR, 11 rotate right.
  function automatic logic [W-1:0] shf(input logic [1:0] c, input logic [4:0] s,
                                       input logic [W-1:0] d);
    int n;
    logic signed [W-1:0] sd;
    n  = int'(s);
    sd = d;
    case (c)
      2'b00:   return (n >= W) ? '0 : (d << n);
      2'b01:   return (n >= W) ? '0 : (d >> n);
      2'b10:   return (n >= W) ? W'(sd >>> (W - 1)) : W'(sd >>> n);
      default: begin
        n = n % W;
        return (d >> n) | (d << (W - n));
      end
    endcase
  endfunction

  always_comb sh_result = shf(sh_control, sh_shamt, sh_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending ops plus a one-deep result slot.
  typedef struct {
    logic [1:0]   c;
    logic [4:0]   s;
    logic [W-1:0] d;
  } op_t;

  op_t          mq[$];
  logic         m_rv = 1'b0;
  logic [W-1:0] m_rd = '0;
  logic [1:0]   m_rc = 2'b00;

  task automatic model_step();
    bit   acc;
    bit   take;
    op_t  h;
    op_t  n;
    if (!rst_n) begin
      mq.delete();
      m_rv = 1'b0;
      m_rd = '0;
      m_rc = 2'b00;
    end else if (flush) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      acc  = in_valid && (mq.size() < D);
      take = (mq.size() > 0) && (!m_rv || res_ready);
      if (take) begin
        h    = mq.pop_front();
        m_rd = shf(h.c, h.s, h.d);
        m_rc = h.c;
        m_rv = 1'b1;
      end else if (m_rv && res_ready) begin
        m_rv = 1'b0;
      end
      if (acc) begin
        n.c = in_control;
        n.s = in_shamt;
        n.d = in_data;
        mq.push_back(n);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmp_level", 32'(level), 32'(mq.size()));
      chk("cmp_in_ready", 32'(in_ready), 32'(mq.size() < D));
      chk("cmp_res_valid", 32'(res_valid), 32'(m_rv));
      chk("cmp_res_data", 32'(res_data), 32'(m_rd));
      chk("cmp_res_control", 32'(res_control), 32'(m_rc));
      if (mq.size() > 0) begin
        chk("cmp_sh_control", 32'(sh_control), 32'(mq[0].c));
        chk("cmp_sh_shamt", 32'(sh_shamt), 32'(mq[0].s));
        chk("cmp_sh_data", 32'(sh_data), 32'(mq[0].d));
      end else begin
        chk("cmp_sh_zero", {19'd0, sh_control, sh_shamt, sh_data}, 32'd0);
      end
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic single(input string nm, input logic [1:0] c, input logic [4:0] s,
                        input logic [W-1:0] d, input logic [W-1:0] exp);
    in_valid = 1'b1; in_control = c; in_shamt = s; in_data = d;
    next();
    in_valid = 1'b0;
    chk({nm, "_not_yet"}, 32'(res_valid), 32'd0);
    next();
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_data"}, 32'(res_data), 32'(exp));
    chk({nm, "_ctl"}, 32'(res_control), 32'(c));
    next();
    chk({nm, "_consumed"}, 32'(res_valid), 32'd0);
  endtask

  task automatic push_n(input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_control = 2'b00; in_shamt = 5'd1; in_data = base + W'(k);
      next();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    bit took;
    repeat (2) next();
    rst_n = 1'b1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    next();

    // Single ops
    res_ready = 1'b1;
    single("lsl", 2'b00, 5'd1, 8'h81, 8'h02);
    single("asr", 2'b10, 5'd3, 8'h80, 8'hF0);
    single("rr",  2'b11, 5'd1, 8'h81, 8'hC0);

    // Fill with consumer stalled
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_control = 2'b00; in_shamt = 5'd1; in_data = W'(16 + acc);
      took = in_ready;
      next();
      if (took) acc++;
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(acc), 32'd5);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_res_data", 32'(res_data), 32'h20);
    next();
    next();
    chk("fill_stable_data", 32'(res_data), 32'h20);
    chk("fill_stable_valid", 32'(res_valid), 32'd1);

    // Drain in order
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(res_valid), 32'd1);
      chk("drain_data", 32'(res_data), 32'(8'h20 + 2 * i));
      next();
    end
    chk("drain_end_valid", 32'(res_valid), 32'd0);
    chk("drain_end_level", 32'(level), 32'd0);

    // Back-to-back across pointer wrap
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        in_valid = 1'b1; in_control = 2'b00; in_shamt = 5'd1; in_data = W'(c);
      end else begin
        in_valid = 1'b0;
      end
      next();
      chk("thru_valid", 32'(res_valid), 32'((c >= 1) && (c <= 10)));
      if (c >= 1 && c <= 10) chk("thru_data", 32'(res_data), 32'(2 * (c - 1)));
      if (c < 10) chk("thru_ready", 32'(in_ready), 32'd1);
    end

    // Flush with a same-cycle push
    res_ready = 1'b0;
    push_n(4, 8'h30);
    chk("pre_flush_level", 32'(level), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    next();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_res_valid", 32'(res_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    res_ready = 1'b1;
    repeat (4) begin
      next();
      chk("flush_no_emerge", 32'(res_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    res_ready = 1'b0;
    push_n(4, 8'h40);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_res_data", 32'(res_data), 32'd0);
    next();
    rst_n = 1'b1;
    next();
    chk("post_rst_level", 32'(level), 32'd0);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
